// File: rtl/wb_port_arb.sv
// wb_port_arb: writeback-port arbiter between the in-order main pipe and a
// long-latency auxiliary unit (divider etc.) sharing the MEM/WB register input.
//
// The aux result is parked in a 1-entry holding buffer and then competes with
// the pipe. The pipe wins by default; after STARVE_LIMIT lost non-stall cycles
// the buffered aux result is forced through.
//
// Optional feature (compile-time macro WB_ARB_WAW_SQUASH_EN): when a granted
// pipe write targets the same destination as a buffered aux write, the stale
// aux entry is dropped. Without the macro the buffered entry always writes back.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   flush                          kills the pipe request this cycle
//   wb_stall                       downstream stall, suppresses every grant
//   pipe_valid/ctrl/dst/result     pipe writeback candidate
//   pipe_ready, pipe_stall_req     pipe granted / pipe must stall upstream
//   aux_valid/ctrl/dst/result      aux unit result offer
//   aux_ready                      aux result captured at the next edge
//   wb_valid/ctrl/dst/result       muxed writeback into MEM/WB
//   wb_src                         0 = pipe, 1 = aux buffer (0 when idle)
module wb_port_arb #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CTRL_W       = 7,
    parameter int unsigned IDX_W        = 3,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wb_stall,
    input  logic              pipe_valid,
    input  logic [CTRL_W-1:0] pipe_ctrl,
    input  logic [IDX_W-1:0]  pipe_dst,
    input  logic [DATA_W-1:0] pipe_result,
    output logic              pipe_ready,
    output logic              pipe_stall_req,
    input  logic              aux_valid,
    input  logic [CTRL_W-1:0] aux_ctrl,
    input  logic [IDX_W-1:0]  aux_dst,
    input  logic [DATA_W-1:0] aux_result,
    output logic              aux_ready,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [IDX_W-1:0]  wb_dst,
    output logic [DATA_W-1:0] wb_result,
    output logic              wb_src
);

    typedef enum logic [0:0] {StNorm, StForce} state_e;

    localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

    state_e             state_q;
    logic               buf_full_q;
    logic [CTRL_W-1:0]  buf_ctrl_q;
    logic [IDX_W-1:0]   buf_dst_q;
    logic [DATA_W-1:0]  buf_result_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic grant_pipe, grant_aux, squash, load;

    // Grants are forced low during reset so every output except aux_ready is 0.
    always_comb begin
        grant_pipe = 1'b0;
        grant_aux  = 1'b0;
        if (!rst && !wb_stall) begin
            if (state_q == StForce && buf_full_q) begin
                grant_aux = 1'b1;
            end else if (pipe_valid && !flush) begin
                grant_pipe = 1'b1;
            end else if (buf_full_q) begin
                grant_aux = 1'b1;
            end
        end
    end

`ifdef WB_ARB_WAW_SQUASH_EN
    // A younger pipe write to the same register makes the buffered aux value stale.
    assign squash = grant_pipe & pipe_ctrl[0] & buf_full_q & buf_ctrl_q[0]
                  & (pipe_dst == buf_dst_q);
`else
    assign squash = 1'b0;
`endif

    // Draining and refilling in the same cycle keeps back-to-back aux results flowing.
    assign aux_ready      = ~buf_full_q | grant_aux | squash;
    assign load           = aux_valid & aux_ready;
    assign pipe_ready     = grant_pipe;
    assign pipe_stall_req = pipe_valid & ~flush & ~grant_pipe & ~rst;

    // Counts cycles the buffered entry lost to the pipe; stall cycles are not losses.
    always_comb begin
        cnt_d = cnt_q;
        if (!buf_full_q || grant_aux || squash) begin
            cnt_d = '0;
        end else if (!wb_stall && cnt_q != Limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StNorm;
            buf_full_q   <= 1'b0;
            buf_ctrl_q   <= '0;
            buf_dst_q    <= '0;
            buf_result_q <= '0;
            cnt_q        <= '0;
        end else begin
            buf_full_q <= load | (buf_full_q & ~grant_aux & ~squash);
            if (load) begin
                buf_ctrl_q   <= aux_ctrl;
                buf_dst_q    <= aux_dst;
                buf_result_q <= aux_result;
            end
            cnt_q <= cnt_d;
            unique case (state_q)
                StNorm:  if (cnt_d == Limit) state_q <= StForce;
                StForce: if (grant_aux)      state_q <= StNorm;
                default: state_q <= StNorm;
            endcase
            if (squash) begin
                state_q <= StNorm;
            end
        end
    end

    always_comb begin
        wb_valid  = 1'b0;
        wb_ctrl   = '0;
        wb_dst    = '0;
        wb_result = '0;
        wb_src    = 1'b0;
        if (grant_pipe) begin
            wb_valid  = 1'b1;
            wb_ctrl   = pipe_ctrl;
            wb_dst    = pipe_dst;
            wb_result = pipe_result;
        end else if (grant_aux) begin
            wb_valid  = 1'b1;
            wb_ctrl   = buf_ctrl_q;
            wb_dst    = buf_dst_q;
            wb_result = buf_result_q;
            wb_src    = 1'b1;
        end
    end

endmodule

// File: doc/wb_port_arb.md
Name: wb_port_arb

Overview:
- Arbitrates the single register-file writeback path (the MEM/WB pipeline register input) between the in-order main pipe and a long-latency auxiliary unit (e.g. divider).
- The aux result is captured into a 1-entry holding buffer. The buffered result then competes with the pipe.
- The pipe has default priority. A starvation counter forces an aux grant after STARVE_LIMIT lost cycles.
- Outputs feed the MEM/WB register combinationally. The block's state is the holding buffer, the counter and the priority FSM.

Parameters:
DATA_W, 32, result width
CTRL_W, 7, control-bundle width; bit 0 is the register-write enable
IDX_W, 3, destination register index width
STARVE_LIMIT, 4, consecutive lost arbitration cycles before aux is forced; legal range 1..7
CNT_W, 3, starvation counter width; must hold STARVE_LIMIT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  kills the pipe request this cycle; aux buffer unaffected
wb_stall  in  1  downstream (MEM/WB) stall; no grant while high
pipe_valid  in  1  pipe has a writeback candidate
pipe_ctrl  in  CTRL_W  pipe control bundle
pipe_dst  in  IDX_W  pipe destination index
pipe_result  in  DATA_W  pipe result
pipe_ready  out  1  pipe candidate granted this cycle
pipe_stall_req  out  1  = pipe_valid & ~flush & ~pipe_ready; stalls upstream
aux_valid  in  1  aux unit offers a result
aux_ctrl  in  CTRL_W  aux control bundle
aux_dst  in  IDX_W  aux destination index
aux_result  in  DATA_W  aux result
aux_ready  out  1  aux result accepted into buffer at next edge
wb_valid  out  1  valid into MEM/WB
wb_ctrl  out  CTRL_W  muxed control to MEM/WB
wb_dst  out  IDX_W  muxed destination index to MEM/WB
wb_result  out  DATA_W  muxed result to MEM/WB
wb_src  out  1  0 = pipe, 1 = aux buffer; 0 when no grant

Behaviour:
- Reset: buf_full=0, buffer contents=0, cnt=0, FSM=NORM.
  - All outputs are combinational and therefore 0 during reset.
  - Exception: aux_ready=1 during reset.
- A reset mid-operation discards the buffered aux result; the aux unit must reissue.
- Grant is combinational, and no grant occurs when wb_stall=1:
  - FSM=FORCE & buf_full -> grant_aux.
  - Else pipe_valid & ~flush -> grant_pipe.
  - Else buf_full -> grant_aux.
  - Else no grant.
- Output mux:
  - grant_pipe: wb_valid=1, wb_* = pipe_*, wb_src=0.
  - grant_aux: wb_valid=1, wb_* = buffer fields, wb_src=1.
  - No grant: wb_valid=0, wb_ctrl/dst/result=0, wb_src=0.
- pipe_ready = grant_pipe.
- aux_ready = ~buf_full | grant_aux. This allows back-to-back aux handoff with a same-cycle drain and refill.
- Buffer load on aux_valid & aux_ready at the clock edge.
  - buf_full next = load | (buf_full & ~grant_aux).
- Starvation counter:
  - Increments when buf_full & ~grant_aux & ~wb_stall; stall cycles do not count.
  - Clears on grant_aux, or when buf_full=0.
  - Saturates at STARVE_LIMIT.
- FSM NORM -> FORCE at the edge where cnt reaches STARVE_LIMIT.
- FSM FORCE -> NORM at the edge of grant_aux. FORCE persists across wb_stall cycles.
- Aux latency: an aux result offered at cycle N is eligible at N+1 at the earliest. Worst-case wait with the pipe continuously valid is STARVE_LIMIT+1 non-stall cycles.
- Flush with pipe_valid: no pipe grant, pipe_ready=0, pipe_stall_req=0. The aux buffer may be granted in the same cycle.
- Flush has no effect on buffer, cnt or FSM beyond the grant outcome.

Optional Feature:
- Macro: WB_ARB_WAW_SQUASH_EN.
- Defined:
  - If grant_pipe & pipe_ctrl[0] & buf_full & buf_ctrl[0] & (pipe_dst == buf_dst), the buffered aux entry is stale and is dropped.
  - Dropping means buf_full, cnt and FSM clear to empty / 0 / NORM at that edge.
  - aux_ready=1 in that cycle; a new aux load the same cycle wins over the clear.
- Undefined:
  - No destination comparison; the buffered entry always eventually writes back.
  - Ordering is the responsibility of issue logic.

Test Plan:
1. Reset: assert rst mid-run with buf_full=1 -> buf_full=0, wb_valid=0, aux_ready=1, FSM=NORM immediately (asynchronous).
2. Pipe only: pipe_valid=1, dst=3, result=0xDEADBEEF -> same cycle wb_valid=1, wb_dst=3, wb_result=0xDEADBEEF, wb_src=0, pipe_ready=1.
3. Starvation, STARVE_LIMIT=4: buffer aux (dst=5, 0x12345678), pipe valid every cycle.
   - Pipe wins 4 cycles.
   - 5th cycle: wb_src=1, wb_result=0x12345678, pipe_stall_req=1.
   - FSM returns to NORM next cycle.
4. Stall and flush:
   - wb_stall=1 for 3 cycles with buf_full -> wb_valid=0, cnt unchanged.
   - flush=1 with pipe_valid -> aux granted, pipe_stall_req=0.
5. Back-to-back aux: buffer full, no pipe, aux_valid held 3 cycles -> aux_ready=1 each cycle, wb_src=1 on 3 consecutive cycles with successive results.
6. WAW (macro defined): buffer dst=2 with ctrl[0]=1; pipe dst=2 with ctrl[0]=1 granted -> buf_full=0 next cycle and the aux value is never written. With the macro undefined, the aux value is written next cycle.
